// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: valid/ready command front-end that issues one op to an ALU unit and returns its result or a timeout.
module alu_cmd_ctrl #(
  parameter int Op_Width       = 16,
  parameter int Timeout_Cycles = 8,
  parameter int Cnt_Width      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Cmd_Valid,
  output logic                Cmd_Ready,
  input  logic [Op_Width-1:0] Cmd_A,
  input  logic [Op_Width-1:0] Cmd_B,
  input  logic [3:0]          Cmd_Fun,
  output logic [Op_Width-1:0] A,
  output logic [Op_Width-1:0] B,
  output logic [1:0]          ALU_FUN,
  output logic                Arith_En,
  output logic                Logic_En,
  output logic                Cmp_En,
  output logic                Shift_En,
  input  logic [Op_Width-1:0] Arith_Out,
  input  logic [Op_Width-1:0] Logic_Out,
  input  logic [Op_Width-1:0] Cmp_Out,
  input  logic [Op_Width-1:0] Shift_Out,
  input  logic                Arith_Flag,
  input  logic                Logic_Flag,
  input  logic                Cmp_Flag,
  input  logic                Shift_Flag,
  output logic [Op_Width-1:0] Res_Out,
  output logic                Res_Valid,
  input  logic                Res_Ready,
  output logic                Timeout_Err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, next;
  logic [1:0] sel;
  logic [Cnt_Width-1:0] cnt;
  logic flag, expired;
  logic [Op_Width-1:0] out;
  logic [3:0] en;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next;
  always_comb begin
    flag = sel == 2'd0 ? Arith_Flag : sel == 2'd1 ? Logic_Flag : sel == 2'd2 ? Cmp_Flag : Shift_Flag;
    out = sel == 2'd0 ? Arith_Out : sel == 2'd1 ? Logic_Out : sel == 2'd2 ? Cmp_Out : Shift_Out;
    expired = cnt == Cnt_Width'(Timeout_Cycles - 1);
    en = (state == ISSUE || state == WAIT) ? 4'b0001 << sel : 4'b0000;
    Cmd_Ready = state == IDLE;
    Res_Valid = state == HOLD;
    next = state;
    case (state)
      IDLE:  next = Cmd_Valid ? ISSUE : IDLE;
      ISSUE: next = WAIT;
      WAIT:  next = (flag || expired) ? HOLD : WAIT;
      HOLD:  next = Res_Ready ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  assign {Shift_En, Cmp_En, Logic_En, Arith_En} = en;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      A <= '0;
      B <= '0;
      ALU_FUN <= '0;
      sel <= '0;
      cnt <= '0;
      Res_Out <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      if (state == IDLE && Cmd_Valid) begin
        A <= Cmd_A;
        B <= Cmd_B;
        ALU_FUN <= Cmd_Fun[1:0];
        sel <= Cmd_Fun[3:2];
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        if (flag) begin
          Res_Out <= out;
          Timeout_Err <= 1'b0;
        end else if (expired) begin
          Res_Out <= '0;
          Timeout_Err <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed vectors against 1-cycle unit models with hand-computed results.
module tb_alu_cmd_ctrl;
  logic CLK, RST, Cmd_Valid, Cmd_Ready, Res_Valid, Res_Ready, Timeout_Err;
  logic [15:0] Cmd_A, Cmd_B, A, B, Res_Out;
  logic [15:0] Arith_Out, Logic_Out, Cmp_Out, Shift_Out;
  logic [3:0] Cmd_Fun, fr, live;
  logic [1:0] ALU_FUN;
  logic Arith_En, Logic_En, Cmp_En, Shift_En;
  logic Arith_Flag, Logic_Flag, Cmp_Flag, Shift_Flag, junk;
  int total, bad;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_Fun(Cmd_Fun), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_En(Arith_En), .Logic_En(Logic_En), .Cmp_En(Cmp_En), .Shift_En(Shift_En),
    .Arith_Out(Arith_Out), .Logic_Out(Logic_Out), .Cmp_Out(Cmp_Out), .Shift_Out(Shift_Out),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .Cmp_Flag(Cmp_Flag), .Shift_Flag(Shift_Flag),
    .Res_Out(Res_Out), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Timeout_Err(Timeout_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unit models: result and flag register one cycle after their enable; junk drives idle units' flags.
  always_ff @(posedge CLK) begin
    fr <= {Shift_En, Cmp_En, Logic_En, Arith_En};
    Arith_Out <= ALU_FUN == 2'd1 ? A - B : A + B;
    Logic_Out <= ALU_FUN == 2'd0 ? A & B : ALU_FUN == 2'd1 ? A | B : ALU_FUN == 2'd2 ? ~(A & B) : A ^ B;
    Cmp_Out <= {15'b0, ALU_FUN == 2'd0 ? A == B : ALU_FUN == 2'd1 ? A > B : ALU_FUN == 2'd2 ? A < B : A != B};
    Shift_Out <= ALU_FUN == 2'd1 ? A >> B[3:0] : A << B[3:0];
  end
  assign Arith_Flag = Arith_En ? fr[0] & live[0] : junk;
  assign Logic_Flag = Logic_En ? fr[1] & live[1] : junk;
  assign Cmp_Flag   = Cmp_En   ? fr[2] & live[2] : junk;
  assign Shift_Flag = Shift_En ? fr[3] & live[3] : junk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp, input logic to, input int lat);
    int k, ecnt;
    Cmd_Valid = 1'b1;
    Cmd_Fun = fun;
    Cmd_A = a;
    Cmd_B = b;
    tick;
    Cmd_Valid = 1'b0;
    k = 1;
    chk({tag, "_en"}, {Shift_En, Cmp_En, Logic_En, Arith_En}, 4'b0001 << fun[3:2]);
    chk({tag, "_fun"}, ALU_FUN, fun[1:0]);
    chk({tag, "_rdy"}, Cmd_Ready, 0);
    ecnt = (Arith_En | Logic_En | Cmp_En | Shift_En) ? 1 : 0;
    while (!Res_Valid && k < 20) begin
      tick;
      k++;
      if (Arith_En | Logic_En | Cmp_En | Shift_En) ecnt++;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_encyc"}, ecnt, lat - 1);
    chk({tag, "_out"}, Res_Out, exp);
    chk({tag, "_to"}, Timeout_Err, to);
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    Cmd_Valid = 1'b0;
    Cmd_A = '0;
    Cmd_B = '0;
    Cmd_Fun = '0;
    Res_Ready = 1'b1;
    live = 4'hf;
    junk = 1'b0;
    #12;
    chk("rst_en", {Shift_En, Cmp_En, Logic_En, Arith_En}, 0);
    chk("rst_out", Res_Out, 0);
    chk("rst_a", {A, B}, 0);
    chk("rst_valid", Res_Valid, 0);
    chk("rst_to", Timeout_Err, 0);
    RST = 1'b0;
    tick;
    chk("idle_rdy", Cmd_Ready, 1);
    chk("idle_en", {Shift_En, Cmp_En, Logic_En, Arith_En}, 0);

    run("and", 4'b0100, 16'h00f0, 16'h0ff0, 16'h00f0, 1'b0, 3);
    tick;
    chk("and_back_rdy", Cmd_Ready, 1);
    chk("and_back_valid", Res_Valid, 0);

    junk = 1'b1;
    run("add", 4'b0000, 16'h1234, 16'h0f04, 16'h2138, 1'b0, 3);
    tick;
    run("or", 4'b0101, 16'h1234, 16'h0f04, 16'h1f34, 1'b0, 3);
    tick;
    run("gt", 4'b1001, 16'h1234, 16'h0f04, 16'h0001, 1'b0, 3);
    tick;
    run("shl", 4'b1100, 16'h1234, 16'h0f04, 16'h2340, 1'b0, 3);
    tick;

    live = 4'b1011;
    run("tmo", 4'b1000, 16'h0007, 16'h0007, 16'h0000, 1'b1, 10);
    chk("tmo_valid", Res_Valid, 1);
    tick;
    live = 4'hf;
    junk = 1'b0;

    Res_Ready = 1'b0;
    run("bp", 4'b1101, 16'h8000, 16'h0003, 16'h1000, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      Cmd_Valid = 1'b1;
      Cmd_A = 16'h5555;
      Cmd_Fun = 4'b0000;
      tick;
      chk("bp_out", Res_Out, 16'h1000);
      chk("bp_valid", Res_Valid, 1);
      chk("bp_rdy", Cmd_Ready, 0);
    end
    chk("bp_a", A, 16'h8000);
    Cmd_Valid = 1'b0;
    Res_Ready = 1'b1;
    tick;
    chk("bp_rel_rdy", Cmd_Ready, 1);
    chk("bp_rel_valid", Res_Valid, 0);

    live = 4'b1101;
    Cmd_Valid = 1'b1;
    Cmd_Fun = 4'b0110;
    Cmd_A = 16'h1111;
    Cmd_B = 16'h2222;
    tick;
    Cmd_Valid = 1'b0;
    tick;
    chk("mid_pre_en", Logic_En, 1);
    #1 RST = 1'b1;
    #1;
    chk("mid_en", {Shift_En, Cmp_En, Logic_En, Arith_En}, 0);
    chk("mid_valid", Res_Valid, 0);
    chk("mid_out", Res_Out, 0);
    chk("mid_a", A, 0);
    #2 RST = 1'b0;
    live = 4'hf;
    tick;
    chk("mid_rdy", Cmd_Ready, 1);
    run("nand", 4'b0110, 16'h0003, 16'h0005, 16'hfffe, 1'b0, 3);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command front-end sitting directly upstream of the 16-bit ALU's function units: arithmetic, logic, compare and shift.
- Accepts one operation at a time through a valid/ready handshake and registers the operands.
- Decodes the 4-bit function code into a unit enable plus the 2-bit unit function, then waits for the selected unit's registered flag.
- Captures the unit's result and presents it downstream through a valid/ready output handshake, with a timeout error if the unit never responds.

Parameters:
- Op_Width, 16, operand and result width.
- Timeout_Cycles, 8, maximum WAIT cycles before aborting (must be >= 1).
- Cnt_Width, 4, width of the timeout counter (must hold Timeout_Cycles).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous reset, active-high.
- Cmd_Valid  input  1  command present.
- Cmd_Ready  output  1  controller can accept a command.
- Cmd_A  input  Op_Width  operand A.
- Cmd_B  input  Op_Width  operand B.
- Cmd_Fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function.
- A  output  Op_Width  registered operand A to units.
- B  output  Op_Width  registered operand B to units.
- ALU_FUN  output  2  registered Cmd_Fun[1:0] to units.
- Arith_En, Logic_En, Cmp_En, Shift_En  output  1 each  one-hot unit enables.
- Arith_Out, Logic_Out, Cmp_Out, Shift_Out  input  Op_Width each  unit registered results.
- Arith_Flag, Logic_Flag, Cmp_Flag, Shift_Flag  input  1 each  unit result-valid flags.
- Res_Out  output  Op_Width  captured result.
- Res_Valid  output  1  result available.
- Res_Ready  input  1  downstream accepts result.
- Timeout_Err  output  1  current Res_Out is an aborted (timeout) result.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE; all of the following cleared:
  - A, B, ALU_FUN, Res_Out = 0.
  - All En = 0; Res_Valid = 0; Timeout_Err = 0; counter = 0.
  - Cmd_Ready = 1 after reset release.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - Cmd_Ready=1 (combinational from state).
  - On Cmd_Valid=1: latch Cmd_A, Cmd_B and Cmd_Fun into A, B, ALU_FUN and unit-select register; go to ISSUE.
- ISSUE:
  - Cmd_Ready=0; selected En=1, others 0; counter cleared.
  - Unconditionally go to WAIT.
- WAIT:
  - Selected En stays 1.
  - If selected unit's Flag=1: capture selected unit's Out into Res_Out, Timeout_Err<=0, go to HOLD.
  - Else counter++. When counter reaches Timeout_Cycles-1 without a flag: Res_Out<=0, Timeout_Err<=1, go to HOLD.
  - Flags of non-selected units are ignored.
- HOLD:
  - All En=0; Res_Valid=1; Res_Out and Timeout_Err held stable.
  - On Res_Ready=1: go to IDLE with Res_Valid<=0 (registered).
- Enables are registered from state: exactly one En high in ISSUE/WAIT, none elsewhere.
- Latency with a 1-cycle unit, accept at edge N:
  - En high in cycles N+1 and N+2.
  - Flag seen in WAIT (cycle N+2); Res_Valid=1 from N+3.
  - Minimum accept-to-accept spacing is 4 cycles with Res_Ready held 1.
- Commands are never accepted outside IDLE. Cmd_Valid deasserting in other states has no effect.
- Backpressure: Res_Ready=0 holds HOLD indefinitely; Res_Out must not change.
- Reset mid-operation (any state): immediate return to reset values.
  - In-flight command is discarded and no Res_Valid is produced.
  - Enables drop asynchronously.
- No width growth: results pass through unchanged at Op_Width.

Test Plan:
- Reset then idle: RST=1 pulse -> all outputs 0, Cmd_Ready=1, no En asserted.
- Logic AND: A=0x00F0, B=0x0FF0, Cmd_Fun=4'b0100, 1-cycle logic unit model -> Logic_En high for 2 cycles, ALU_FUN=00, Res_Out=0x00F0 with Res_Valid 3 cycles after accept, Timeout_Err=0.
- Decode sweep: Cmd_Fun[3:2]=00/01/10/11 -> only Arith_En / Logic_En / Cmp_En / Shift_En respectively asserts; Res_Out equals the selected unit's Out; wrong-unit flags ignored.
- Timeout: Cmd_Fun=4'b1000, cmp unit model never raises Cmp_Flag, Timeout_Cycles=8 -> HOLD after 8 WAIT cycles with Res_Out=0x0000, Timeout_Err=1, Res_Valid=1.
- Backpressure: Res_Ready=0 for 5 cycles after Res_Valid -> Res_Out stable, Cmd_Ready=0, second Cmd_Valid ignored; Res_Ready=1 -> IDLE next cycle, Cmd_Ready=1.
- Reset mid-WAIT: assert RST during WAIT -> En and Res_Valid drop immediately; after release, next command 0x0003 NAND 0x0005 (Fun=4'b0110) yields Res_Out=0xFFFE.
